cpu_read_responder: RTL and testbench
=====================================

CPU_READ_RESPONDER -- requirements
Module: cpu_read_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 14, BRAM word-address width.
REQ-002 Parameter READ_LATENCY, 2, fixed BRAM read latency in CLK cycles (1..4).
REQ-003 CLK  in  1  CPU bus clock (CPU_CKIO domain); the block SHALL use this single clock only.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 EN  in  1  chip select, active-high (inverted CS1_N).
REQ-006 RD  in  1  read strobe, active-high (inverted RD_N).
REQ-007 RDWR  in  1  1 = read cycle, 0 = write cycle.
REQ-008 BRAM_SELECT  in  2  target BRAM bank; 3 = reserved.
REQ-009 BRAM_ADDR  in  ADDR_WIDTH  word address.
REQ-010 RD_EN  out  1  one-cycle BRAM read request.
REQ-011 RD_SEL  out  2  latched bank for the read.
REQ-012 RD_ADDR  out  ADDR_WIDTH  latched address for the read.
REQ-013 RD_DATA  in  16  BRAM read data, valid READ_LATENCY cycles after RD_EN.
REQ-014 DATA_OUT  out  16  registered data for the CPU_DATA tristate driver.
REQ-015 DATA_OE  out  1  tristate output enable for CPU_DATA.
REQ-016 ABORT_CNT  out  8  saturating count of reads aborted before data was driven.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, DRIVE, TURN.
REQ-018 A read start SHALL be a cycle c0 where EN=1, RDWR=1, RD=1 and the registered RD of the previous cycle was 0.
REQ-019 In IDLE, on read start at c0: latch BRAM_SELECT/BRAM_ADDR into RD_SEL/RD_ADDR, assert RD_EN for exactly cycle c0+1, enter WAIT.
REQ-020 For RD_SEL=3, RD_EN SHALL stay 0 and the captured data SHALL be 16'h0000 with identical timing.
REQ-021 WAIT SHALL last READ_LATENCY cycles; at c0+1+READ_LATENCY, RD_DATA is captured into DATA_OUT and the FSM enters DRIVE.
REQ-022 DATA_OE SHALL be 1 exactly while in DRIVE; first OE cycle = c0+2+READ_LATENCY (c0+4 at default).
REQ-023 DATA_OUT SHALL hold constant throughout DRIVE.
REQ-024 DRIVE SHALL persist while EN=1 and RD=1; when either is 0, enter TURN (OE=0) for exactly one cycle, then IDLE.
REQ-025 If EN or RD drops during WAIT, return to IDLE, never assert OE, and increment ABORT_CNT (saturate at 255).
REQ-026 A read start detected in TURN SHALL be held in a one-deep pending flag and serviced from IDLE in the next cycle, with latency measured from IDLE.
REQ-027 Write cycles (RDWR=0) SHALL never assert RD_EN or DATA_OE.
REQ-028 DATA_OUT SHALL be left unchanged outside DRIVE (no glitch to 0).

Reset
REQ-029 On RST=1 at a CLK edge: state=IDLE, RD_EN=0, DATA_OE=0, DATA_OUT=0, RD_SEL=0, RD_ADDR=0, ABORT_CNT=0, pending=0, RD history=1.
REQ-030 RST in any state, including DRIVE, SHALL drop DATA_OE on the next edge.
REQ-031 RD history reset to 1 SHALL prevent a read already in progress at reset release from being treated as a start.

Structure
REQ-032 Bank-select encodings (including reserved value 3) and the FSM state enum SHALL live in the shared params package.
REQ-033 The block SHALL be one module with no sub-modules; the tristate buffer SHALL stay in top.

Verification
REQ-034 Read start at c0, SEL=1, ADDR=0x0123, RD_DATA=0xBEEF -> RD_EN at c0+1 only, OE at c0+4, DATA_OUT=0xBEEF, OE low one cycle after RD drops.
REQ-035 SEL=3, ADDR=0x0010 -> RD_EN never asserts, DATA_OUT=0x0000 with OE at c0+4.
REQ-036 RD deasserted at c0+2 -> OE never asserts, ABORT_CNT 0->1; 300 aborts -> ABORT_CNT=255.
REQ-037 Back-to-back: RD re-rises in the TURN cycle with ADDR=0x0200 -> second RD_EN one cycle after IDLE entry, correct second datum driven.
REQ-038 RST pulsed during DRIVE with RD still high -> OE=0 next cycle and no new read after release until RD goes 0 then 1.
REQ-039 Write cycle, RDWR=0 with RD toggling -> RD_EN and DATA_OE stay 0.

Source files
------------

// File: rtl/cpu_read_responder_pkg.sv
// Shared bank-select encodings, FSM states and constants for the CPU read responder.
package cpu_read_responder_pkg;

  typedef enum logic [1:0] {
    BANK0     = 2'd0,
    BANK1     = 2'd1,
    BANK2     = 2'd2,
    BANK_RSVD = 2'd3
  } bank_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_e;

  // Value returned to the CPU when the reserved bank is addressed.
  localparam logic [15:0] RSVD_DATA = 16'h0000;

endpackage

// File: rtl/cpu_read_responder_if.sv
// CPU bus / BRAM read-port bundle seen by the read responder.
interface cpu_read_responder_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  EN;
  logic                  RD;
  logic                  RDWR;
  logic [1:0]            BRAM_SELECT;
  logic [ADDR_WIDTH-1:0] BRAM_ADDR;
  logic                  RD_EN;
  logic [1:0]            RD_SEL;
  logic [ADDR_WIDTH-1:0] RD_ADDR;
  logic [15:0]           RD_DATA;
  logic [15:0]           DATA_OUT;
  logic                  DATA_OE;
  logic [7:0]            ABORT_CNT;

  modport master (
    output EN, RD, RDWR, BRAM_SELECT, BRAM_ADDR, RD_DATA,
    input  RD_EN, RD_SEL, RD_ADDR, DATA_OUT, DATA_OE, ABORT_CNT
  );

  modport slave (
    input  EN, RD, RDWR, BRAM_SELECT, BRAM_ADDR, RD_DATA,
    output RD_EN, RD_SEL, RD_ADDR, DATA_OUT, DATA_OE, ABORT_CNT
  );
endinterface

// File: rtl/cpu_read_responder.sv
// Turns CPU read strobes into timed BRAM reads and drives the captured word
// onto the CPU data bus; the tristate buffer itself lives one level up.
module cpu_read_responder
  import cpu_read_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  cpu_read_responder_if.slave  bus
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

  state_e                state_reg, state_next;
  logic                  rd_hist_reg;
  logic                  pending_reg, pending_next;
  logic                  rd_en_reg, rd_en_next;
  logic [1:0]            sel_reg, sel_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]           data_reg, data_next;
  logic [7:0]            abort_reg, abort_next;
  logic [2:0]            wait_cnt_reg, wait_cnt_next;
  logic                  read_start;
  logic                  bus_held;

  // A start is the rising edge of RD inside an active read cycle.
  assign read_start = bus.EN & bus.RDWR & bus.RD & ~rd_hist_reg;
  assign bus_held   = bus.EN & bus.RD;

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    rd_en_next    = 1'b0;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    abort_next    = abort_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (read_start || pending_reg) begin
          sel_next      = bus.BRAM_SELECT;
          addr_next     = bus.BRAM_ADDR;
          rd_en_next    = (bus.BRAM_SELECT != BANK_RSVD);
          wait_cnt_next = 3'd0;
          pending_next  = 1'b0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (!bus_held) begin
          state_next = IDLE;
          if (abort_reg != 8'hFF) begin
            abort_next = abort_reg + 8'd1;
          end
        end else if (wait_cnt_reg == LAT_LAST) begin
          // Counter starts in the RD_EN cycle, so this is the data-valid cycle.
          data_next  = (sel_reg == BANK_RSVD) ? RSVD_DATA : bus.RD_DATA;
          state_next = DRIVE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 3'd1;
        end
      end
      DRIVE: begin
        if (!bus_held) begin
          state_next = TURN;
        end
      end
      TURN: begin
        state_next = IDLE;
        if (read_start) begin
          pending_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      rd_hist_reg  <= 1'b1;
      pending_reg  <= 1'b0;
      rd_en_reg    <= 1'b0;
      sel_reg      <= 2'd0;
      addr_reg     <= '0;
      data_reg     <= 16'h0000;
      abort_reg    <= 8'd0;
      wait_cnt_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      rd_hist_reg  <= bus.RD;
      pending_reg  <= pending_next;
      rd_en_reg    <= rd_en_next;
      sel_reg      <= sel_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      abort_reg    <= abort_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign bus.RD_EN     = rd_en_reg;
  assign bus.RD_SEL    = sel_reg;
  assign bus.RD_ADDR   = addr_reg;
  assign bus.DATA_OUT  = data_reg;
  assign bus.DATA_OE   = (state_reg == DRIVE);
  assign bus.ABORT_CNT = abort_reg;

endmodule

// File: tb/tb_cpu_read_responder.sv
// Directed bench for cpu_read_responder: cycle table plus abort, back-to-back and reset sequences.
module tb_cpu_read_responder;

  localparam int AW  = 14;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cpu_read_responder_if #(.ADDR_WIDTH(AW)) bus ();

  cpu_read_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // BRAM model: data valid exactly LAT cycles after the RD_EN cycle, junk otherwise.
  function automatic logic [15:0] bram(input logic [1:0] sel, input logic [AW-1:0] addr);
    if (addr == 14'h0123) return 16'hBEEF;
    if (addr == 14'h0200) return 16'hCAFE;
    return {sel, addr};
  endfunction

  logic [LAT-1:0] v_pipe;
  logic [15:0]    d_pipe [LAT];

  always @(posedge CLK) begin
    if (RST) begin
      v_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[LAT-2:0], bus.RD_EN};
    end
    d_pipe[0] <= bram(bus.RD_SEL, bus.RD_ADDR);
    for (int i = LAT - 1; i > 0; i--) begin
      d_pipe[i] <= d_pipe[i-1];
    end
  end

  assign bus.RD_DATA = v_pipe[LAT-1] ? d_pipe[LAT-1] : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        en, rd, rdwr;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic        x_rd_en, x_oe;
    logic [15:0] x_data;
  } vec_t;

  vec_t tbl [24];

  task automatic v(input int i, input logic en, input logic rd, input logic rdwr,
                   input logic [1:0] sel, input logic [13:0] addr,
                   input logic xr, input logic xo, input logic [15:0] xd);
    tbl[i] = '{en, rd, rdwr, sel, addr, xr, xo, xd};
  endtask

  task automatic run_abort(output logic oe_seen);
    oe_seen = 1'b0;
    bus.RD = 1'b0; step();
    bus.RD = 1'b1; step();
    oe_seen |= bus.DATA_OE; step();
    oe_seen |= bus.DATA_OE;
    bus.RD = 1'b0; step();
    oe_seen |= bus.DATA_OE; step();
    oe_seen |= bus.DATA_OE;
  endtask

  logic flag;

  initial begin
    // Read at sel 1 / 0x123, then reserved bank, then write cycles with RD toggling.
    v(0,  1,0,1, 2'd1,14'h123, 0,0,16'h0000);
    v(1,  1,1,1, 2'd1,14'h123, 0,0,16'h0000);
    v(2,  1,1,1, 2'd1,14'h123, 1,0,16'h0000);
    v(3,  1,1,1, 2'd1,14'h123, 0,0,16'h0000);
    v(4,  1,1,1, 2'd1,14'h123, 0,0,16'h0000);
    v(5,  1,1,1, 2'd1,14'h123, 0,1,16'hBEEF);
    v(6,  1,0,1, 2'd1,14'h123, 0,1,16'hBEEF);
    v(7,  1,0,1, 2'd1,14'h123, 0,0,16'hBEEF);
    v(8,  1,0,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(9,  1,0,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(10, 1,1,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(11, 1,1,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(12, 1,1,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(13, 1,1,1, 2'd3,14'h010, 0,0,16'hBEEF);
    v(14, 1,1,1, 2'd3,14'h010, 0,1,16'h0000);
    v(15, 1,0,1, 2'd3,14'h010, 0,1,16'h0000);
    v(16, 1,0,1, 2'd3,14'h010, 0,0,16'h0000);
    v(17, 1,0,0, 2'd2,14'h040, 0,0,16'h0000);
    v(18, 1,1,0, 2'd2,14'h040, 0,0,16'h0000);
    v(19, 1,0,0, 2'd2,14'h040, 0,0,16'h0000);
    v(20, 1,1,0, 2'd2,14'h040, 0,0,16'h0000);
    v(21, 1,0,0, 2'd2,14'h040, 0,0,16'h0000);
    v(22, 1,1,0, 2'd2,14'h040, 0,0,16'h0000);
    v(23, 1,0,0, 2'd2,14'h040, 0,0,16'h0000);

    bus.EN = 1'b0; bus.RD = 1'b0; bus.RDWR = 1'b1;
    bus.BRAM_SELECT = 2'd0; bus.BRAM_ADDR = '0;
    RST = 1'b1;
    step(); step();
    check("reset_rd_en",  32'(bus.RD_EN),     32'd0);
    check("reset_oe",     32'(bus.DATA_OE),   32'd0);
    check("reset_data",   32'(bus.DATA_OUT),  32'd0);
    check("reset_sel",    32'(bus.RD_SEL),    32'd0);
    check("reset_addr",   32'(bus.RD_ADDR),   32'd0);
    check("reset_abort",  32'(bus.ABORT_CNT), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bus.EN = tbl[i].en; bus.RD = tbl[i].rd; bus.RDWR = tbl[i].rdwr;
      bus.BRAM_SELECT = tbl[i].sel; bus.BRAM_ADDR = tbl[i].addr;
      check($sformatf("tbl%0d_rd_en", i), 32'(bus.RD_EN),    32'(tbl[i].x_rd_en));
      check($sformatf("tbl%0d_oe", i),    32'(bus.DATA_OE),  32'(tbl[i].x_oe));
      check($sformatf("tbl%0d_data", i),  32'(bus.DATA_OUT), 32'(tbl[i].x_data));
      if (i == 3) begin
        check("tbl_latched_addr", 32'(bus.RD_ADDR), 32'h123);
        check("tbl_latched_sel",  32'(bus.RD_SEL),  32'd1);
      end
      step();
    end

    // Aborted reads: RD drops at c0+2.
    bus.RDWR = 1'b1; bus.BRAM_SELECT = 2'd1; bus.BRAM_ADDR = 14'h0055;
    run_abort(flag);
    check("abort_oe_never", 32'(flag), 32'd0);
    check("abort_cnt_1",    32'(bus.ABORT_CNT), 32'd1);
    check("abort_addr",     32'(bus.RD_ADDR), 32'h55);
    for (int i = 1; i < 254; i++) run_abort(flag);
    check("abort_cnt_254", 32'(bus.ABORT_CNT), 32'd254);
    for (int i = 254; i < 300; i++) run_abort(flag);
    check("abort_cnt_sat", 32'(bus.ABORT_CNT), 32'd255);

    // Back-to-back: RD re-rises during TURN with a new address.
    bus.BRAM_ADDR = 14'h0123;
    bus.RD = 1'b0; step();
    bus.RD = 1'b1; step(); step(); step(); step();
    check("b2b_first_oe",   32'(bus.DATA_OE),  32'd1);
    check("b2b_first_data", 32'(bus.DATA_OUT), 32'hBEEF);
    bus.RD = 1'b0; step();
    check("b2b_turn_oe", 32'(bus.DATA_OE), 32'd0);
    bus.RD = 1'b1; bus.BRAM_ADDR = 14'h0200; step();
    check("b2b_idle_rd_en", 32'(bus.RD_EN), 32'd0);
    step();
    check("b2b_rd_en",   32'(bus.RD_EN),   32'd1);
    check("b2b_rd_addr", 32'(bus.RD_ADDR), 32'h200);
    step();
    check("b2b_rd_en_once", 32'(bus.RD_EN), 32'd0);
    step();
    check("b2b_wait_oe", 32'(bus.DATA_OE), 32'd0);
    step();
    check("b2b_second_oe",   32'(bus.DATA_OE),  32'd1);
    check("b2b_second_data", 32'(bus.DATA_OUT), 32'hCAFE);
    bus.RD = 1'b0; step(); step();

    // Reset while driving, RD held high through release.
    bus.BRAM_ADDR = 14'h0123;
    bus.RD = 1'b1; step(); step(); step(); step();
    check("rst_pre_oe", 32'(bus.DATA_OE), 32'd1);
    RST = 1'b1; step();
    check("rst_drive_oe",   32'(bus.DATA_OE),  32'd0);
    check("rst_drive_data", 32'(bus.DATA_OUT), 32'd0);
    RST = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      flag |= bus.RD_EN | bus.DATA_OE;
    end
    check("rst_no_restart", 32'(flag), 32'd0);
    bus.RD = 1'b0; step();
    bus.RD = 1'b1; step();
    check("rst_new_rd_en", 32'(bus.RD_EN), 32'd1);
    step(); step(); step();
    check("rst_new_oe",   32'(bus.DATA_OE),  32'd1);
    check("rst_new_data", 32'(bus.DATA_OUT), 32'hBEEF);
    bus.RD = 1'b0; step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
